// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for small combinational blocks: drives every input vector,
// samples F after SETTLE cycles and compares it against an expected table. Optional: TTS_STOP_ON_FAIL_EN.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_table,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   SETTLE_ONE  = CW'(1);
  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE     = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   settle_r;
  logic            settle_hit_s;
  logic            miss_s;
  logic            last_s;

  assign settle_hit_s = (settle_r == SETTLE_LAST);
  assign miss_s       = (f_in != exp_table[vec_out]);
  assign last_s       = (vec_out == LAST_VEC);
  assign busy         = (state_r != S_IDLE);
  assign done         = (state_r == S_FINISH);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_WAIT;
        else       state_nxt_s = S_IDLE;
      end
      S_WAIT: begin
        if (settle_hit_s) state_nxt_s = S_SAMPLE;
        else              state_nxt_s = S_WAIT;
      end
      S_SAMPLE: begin
`ifdef TTS_STOP_ON_FAIL_EN
        if (miss_s || last_s) state_nxt_s = S_FINISH;
        else                  state_nxt_s = S_WAIT;
`else
        if (last_s) state_nxt_s = S_FINISH;
        else        state_nxt_s = S_WAIT;
`endif
      end
      S_FINISH: state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Sweep datapath: vector stepping, table capture and mismatch bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_out      <= '0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      fail_idx     <= '0;
      pass         <= 1'b0;
      settle_r     <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            vec_out      <= '0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            fail_idx     <= '0;
            pass         <= 1'b0;
            settle_r     <= '0;
          end
        end
        S_WAIT: begin
          settle_r <= settle_r + SETTLE_ONE;
        end
        S_SAMPLE: begin
          table_out[vec_out] <= f_in;
          if (miss_s) begin
            mismatch_cnt <= mismatch_cnt + CNT_ONE;
            // A zero count before this edge means this is the first failing entry
            if (mismatch_cnt == '0) fail_idx <= vec_out;
          end
          if (state_nxt_s == S_WAIT) begin
            vec_out  <= vec_out + VEC_ONE;
            settle_r <= '0;
          end
        end
        S_FINISH: begin
          pass <= (mismatch_cnt == '0);
        end
        default: begin
          settle_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed scoreboard bench for truth_table_sweeper (default 4-input/SETTLE=2 and a 2-input/SETTLE=1 instance).
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
    logic [4:0]  cnt;
    logic [3:0]  fidx;
    logic [3:0]  vec;
    int          done_edge;
  } exp_t;

  exp_t sb_q[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          tests = 0;
  int          fails = 0;

  logic        start_a = 1'b0;
  logic [15:0] exp_a = 16'h0000;
  logic        f_a;
  logic [3:0]  vec_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] table_a;
  logic [4:0]  cnt_a;
  logic [3:0]  fidx_a;
  int          mode = 0;

  logic        start_b = 1'b0;
  logic [3:0]  exp_b = 4'b0110;
  logic        f_b;
  logic [1:0]  vec_b;
  logic        busy_b, done_b, pass_b;
  logic [3:0]  table_b;
  logic [2:0]  cnt_b;
  logic [1:0]  fidx_b;

  always #5 clk = ~clk;

  assign f_a = (mode == 0) ? (vec_a[3] & vec_a[2]) : (mode == 1) ? vec_a[0] : ~vec_a[0];
  assign f_b = vec_b[1] ^ vec_b[0];

  truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .exp_table(exp_a), .f_in(f_a),
    .vec_out(vec_a), .busy(busy_a), .done(done_a), .table_out(table_a),
    .pass(pass_a), .mismatch_cnt(cnt_a), .fail_idx(fidx_a)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .exp_table(exp_b), .f_in(f_b),
    .vec_out(vec_b), .busy(busy_b), .done(done_b), .table_out(table_b),
    .pass(pass_b), .mismatch_cnt(cnt_b), .fail_idx(fidx_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Runs one sweep on dut_a; start is high on edge 0 and on the extra edges x1..x3 (-1 = unused)
  task automatic run_a(input int m, input logic [15:0] expt, input exp_t e,
                       input int x1, input int x2, input int x3, input bit chk_steps);
    int   done_cnt;
    int   done_edge;
    exp_t got;
    done_cnt  = 0;
    done_edge = -1;
    mode  = m;
    exp_a = expt;
    sb_q.push_back(e);
    for (int k = 0; k <= 62; k++) begin
      @(negedge clk);
      start_a = (k == 0) || (k == x1) || (k == x2) || (k == x3);
      @(posedge clk);
      #1;
      if (done_a) begin
        done_cnt++;
        done_edge = k;
      end
      if (chk_steps && (k % 3 == 0) && (k < 48)) chk("vec_step", 32'(vec_a), 32'(k / 3));
    end
    @(negedge clk);
    start_a = 1'b0;
    got = sb_q.pop_front();
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_edge", 32'(done_edge), 32'(got.done_edge));
    chk("busy_idle", 32'(busy_a), 32'd0);
    chk("table_out", 32'(table_a), 32'(got.tbl));
    chk("pass", 32'(pass_a), 32'(got.pass));
    chk("mismatch_cnt", 32'(cnt_a), 32'(got.cnt));
    chk("fail_idx", 32'(fidx_a), 32'(got.fidx));
    chk("vec_end", 32'(vec_a), 32'(got.vec));
  endtask

  initial begin
    int   done_seen;
    int   done_edge;
    exp_t e;
    exp_t got;

    #1 rst = 1'b1;
    #1;
    chk("rst_vec", 32'(vec_a), 32'd0);
    chk("rst_table", 32'(table_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_fidx", 32'(fidx_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // A&B against F000: clean pass
    e = '{tbl: 16'hF000, pass: 1'b1, cnt: 5'd0, fidx: 4'd0, vec: 4'd15, done_edge: 48};
    run_a(0, 16'hF000, e, -1, -1, -1, 1'b1);

    // F=D against AAAB: single mismatch at vector 0
`ifdef TTS_STOP_ON_FAIL_EN
    e = '{tbl: 16'h0000, pass: 1'b0, cnt: 5'd1, fidx: 4'd0, vec: 4'd0, done_edge: 3};
`else
    e = '{tbl: 16'hAAAA, pass: 1'b0, cnt: 5'd1, fidx: 4'd0, vec: 4'd15, done_edge: 48};
`endif
    run_a(1, 16'hAAAB, e, -1, -1, -1, 1'b0);

    // F=~D against AAAA: every entry mismatches
`ifdef TTS_STOP_ON_FAIL_EN
    e = '{tbl: 16'h0001, pass: 1'b0, cnt: 5'd1, fidx: 4'd0, vec: 4'd0, done_edge: 3};
`else
    e = '{tbl: 16'h5555, pass: 1'b0, cnt: 5'b10000, fidx: 4'd0, vec: 4'd15, done_edge: 48};
`endif
    run_a(2, 16'hAAAA, e, -1, -1, -1, 1'b0);

    // Start while busy and start held through FINISH must not restart
    e = '{tbl: 16'hF000, pass: 1'b1, cnt: 5'd0, fidx: 4'd0, vec: 4'd15, done_edge: 48};
    run_a(0, 16'hF000, e, 10, 48, 49, 1'b0);

    // Asynchronous reset mid-sweep while vec_out=5
    mode  = 1;
    exp_a = 16'hF000;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      start_a = (k == 0);
      @(posedge clk);
      #1;
    end
    chk("mid_vec5", 32'(vec_a), 32'd5);
    chk("mid_table_nonzero", 32'(table_a != 16'h0000), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vec", 32'(vec_a), 32'd0);
    chk("mid_rst_table", 32'(table_a), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
    chk("mid_rst_fidx", 32'(fidx_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) done_seen++;
    end
    chk("post_rst_quiet", 32'(done_seen), 32'd0);
    e = '{tbl: 16'hF000, pass: 1'b1, cnt: 5'd0, fidx: 4'd0, vec: 4'd15, done_edge: 48};
    run_a(0, 16'hF000, e, -1, -1, -1, 1'b1);

    // Two-input instance with SETTLE=1, F=A^B
    e = '{tbl: 16'h0006, pass: 1'b1, cnt: 5'd0, fidx: 4'd0, vec: 4'd3, done_edge: 8};
    sb_q.push_back(e);
    done_seen = 0;
    done_edge = -1;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      start_b = (k == 0);
      @(posedge clk);
      #1;
      if (done_b) begin
        done_seen++;
        done_edge = k;
      end
    end
    got = sb_q.pop_front();
    chk("b_done_count", 32'(done_seen), 32'd1);
    chk("b_done_edge", 32'(done_edge), 32'(got.done_edge));
    chk("b_table", 32'(table_b), 32'(got.tbl[3:0]));
    chk("b_pass", 32'(pass_b), 32'(got.pass));
    chk("b_cnt", 32'(cnt_b), 32'(got.cnt[2:0]));
    chk("b_fidx", 32'(fidx_b), 32'(got.fidx[1:0]));
    chk("b_vec_end", 32'(vec_b), 32'(got.vec[1:0]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
